pwm_breathe_multi: RTL and testbench

PWM_BREATHE_MULTI -- requirements
Module: pwm_breathe_multi

---
 rtl/pwm_breathe_multi.sv | 96 +++++++++
 tb/tb_pwm_breathe_multi.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pwm_breathe_multi.sv
// Multi-channel LED breathing engine: triangle-ramped duty per channel driving a shared
// PWM counter, with off / breathe / full-on / blink output modes.
module pwm_breathe_multi #(
  parameter int CHANNELS  = 4,
  parameter int PWM_WIDTH = 8,
  parameter int BASE_DIV  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [1:0]          speed_ctrl,
  output logic [CHANNELS-1:0] led_out,
  output logic                wave_done
);

  localparam int W  = PWM_WIDTH;
  localparam int NW = $clog2(BASE_DIV) + 1;
  localparam logic [W-1:0] MAX      = '1;
  localparam logic [W-1:0] CNT_LAST = MAX - 1'b1;

  logic [W-1:0]        pwm_cnt;
  logic [NW-1:0]       presc;
  logic [NW-1:0]       n_cur;
  logic [NW-1:0]       n_next;
  logic [W-1:0]        duty [CHANNELS];
  logic [CHANNELS-1:0] dir;
  logic                period_end;
  logic                step_tick;

  function automatic logic [NW-1:0] interval(input logic [1:0] sel);
    logic [NW-1:0] v;
    v = NW'(BASE_DIV) >> sel;
    return (v == '0) ? NW'(1) : v;
  endfunction

  always_comb begin
    n_next     = interval(speed_ctrl);
    period_end = (pwm_cnt == CNT_LAST);
    step_tick  = enable && period_end && (presc == n_cur - NW'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      presc     <= '0;
      n_cur     <= n_next;
      led_out   <= '0;
      wave_done <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty[i] <= W'((i * (2 ** W)) / CHANNELS);
        dir[i]  <= 1'b1;
      end
    end else if (!enable) begin
      led_out   <= '0;
      wave_done <= 1'b0;
    end else begin
      pwm_cnt <= period_end ? '0 : pwm_cnt + 1'b1;
      if (period_end)
        presc <= step_tick ? '0 : presc + 1'b1;
      // speed is only re-sampled at a step boundary so a change never cuts an interval short
      if (step_tick)
        n_cur <= n_next;

      for (int i = 0; i < CHANNELS; i++) begin
        case (mode)
          2'b00:   led_out[i] <= 1'b0;
          2'b01:   led_out[i] <= (pwm_cnt < duty[i]);
          2'b10:   led_out[i] <= 1'b1;
          default: led_out[i] <= dir[i];
        endcase

        if (step_tick) begin
          if (dir[i]) begin
            if (duty[i] == MAX) begin
              dir[i]  <= 1'b0;
              duty[i] <= MAX - 1'b1;
            end else begin
              duty[i] <= duty[i] + 1'b1;
            end
          end else begin
            if (duty[i] == '0) begin
              dir[i]  <= 1'b1;
              duty[i] <= W'(1);
            end else begin
              duty[i] <= duty[i] - 1'b1;
            end
          end
        end
      end

      wave_done <= step_tick && !dir[0] && (duty[0] == W'(1));
    end
  end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Bench for pwm_breathe_multi (W=4, 2 channels, BASE_DIV=2): per-clock comparison against a
// step-count based triangle model, segment table, random segments and corner sequences.
module tb_pwm_breathe_multi;
  localparam int W = 4, CH = 2, BD = 2, MAXV = 15, BREATH = 2 * MAXV;

  logic          clk = 0, rst_n = 0, enable = 0;
  logic [1:0]    mode = 0, speed_ctrl = 0;
  logic [CH-1:0] led_out;
  logic          wave_done;

  always #5 clk = ~clk;

  pwm_breathe_multi #(.CHANNELS(CH), .PWM_WIDTH(W), .BASE_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .speed_ctrl(speed_ctrl), .led_out(led_out), .wave_done(wave_done));

  int n_cmp = 0, n_err = 0;
  int m_cnt, m_presc, m_n, m_s;
  int edge_no, pulses, first_pulse, last_pulse;

  typedef struct {
    bit       en;
    bit [1:0] md;
    bit [1:0] sp;
    int       cycles;
    int       exp_pulses;   // -1: not checked
  } seg_t;
  seg_t segs[5];

  function automatic int interval(int sp);
    int v = BD >> sp;
    return (v == 0) ? 1 : v;
  endfunction

  // Position on a 2*MAX-step triangle; channel i starts at i*2^W/CH.
  function automatic int tri_pos(int ch, int s);
    return ((ch * (1 << W)) / CH + s) % BREATH;
  endfunction
  function automatic int duty_of(int ch, int s);
    int p = tri_pos(ch, s);
    return (p <= MAXV) ? p : BREATH - p;
  endfunction
  function automatic bit dir_of(int ch, int s);
    int p = tri_pos(ch, s);
    if (s == 0) return 1'b1;
    return (p >= 1) && (p <= MAXV);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
    end
  endtask

  task automatic clk1();
    logic [CH-1:0] e_led;
    logic e_wd;
    bit tick;
    e_led = '0;
    e_wd = 1'b0;
    if (!rst_n) begin
      m_cnt = 0; m_presc = 0; m_s = 0; m_n = interval(speed_ctrl);
    end else if (enable) begin
      for (int i = 0; i < CH; i++) begin
        case (mode)
          2'd0: e_led[i] = 1'b0;
          2'd1: e_led[i] = (m_cnt < duty_of(i, m_s));
          2'd2: e_led[i] = 1'b1;
          default: e_led[i] = dir_of(i, m_s);
        endcase
      end
      tick = (m_cnt == MAXV - 1) && (m_presc == m_n - 1);
      e_wd = tick && (((m_s + 1) % BREATH) == 0);
      if (m_cnt == MAXV - 1) m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin m_s++; m_n = interval(speed_ctrl); end
      m_cnt = (m_cnt + 1) % MAXV;
    end
    @(posedge clk); #1;
    edge_no++;
    check("led_out", led_out, e_led);
    check("wave_done", wave_done, e_wd);
    if (wave_done === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = edge_no;
      last_pulse = edge_no;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    clk1();
    rst_n = 1;
    edge_no = 0; pulses = 0; first_pulse = -1; last_pulse = -1;
  endtask

  initial begin
    int hi0, hi1, first_hi;
    segs[0] = '{1'b1, 2'd2, 2'd3, 15, 0};
    segs[1] = '{1'b1, 2'd3, 2'd0, 60, 0};
    segs[2] = '{1'b0, 2'd1, 2'd0, 40, 0};
    segs[3] = '{1'b1, 2'd1, 2'd0, 200, -1};
    segs[4] = '{1'b1, 2'd0, 2'd2, 100, -1};

    // Reset state, first period and two full breaths at N=1
    enable = 1; mode = 2'd1; speed_ctrl = 2'd3;
    do_reset();
    check("reset_led", led_out, 0);
    check("reset_wd", wave_done, 0);
    hi0 = 0; hi1 = 0; first_hi = -1;
    for (int c = 0; c < MAXV; c++) begin
      clk1();
      if (led_out[0]) hi0++;
      if (led_out[1]) begin hi1++; if (first_hi < 0) first_hi = edge_no; end
    end
    check("p1_ch0_high", hi0, 0);
    check("p1_ch1_high", hi1, 8);
    check("p1_ch1_first", first_hi, 1);
    for (int c = MAXV; c < 900; c++) clk1();
    check("breath_pulses", pulses, 2);
    check("first_pulse_edge", first_pulse, 450);
    check("second_pulse_edge", last_pulse, 900);

    // Mode / speed / enable segments continuing from the same state
    foreach (segs[k]) begin
      enable = segs[k].en; mode = segs[k].md; speed_ctrl = segs[k].sp;
      pulses = 0;
      for (int c = 0; c < segs[k].cycles; c++) begin
        clk1();
        if (c == 0 && segs[k].md == 2'd2 && segs[k].en) check("full_on_next", led_out, 2'b11);
      end
      if (segs[k].exp_pulses >= 0) check($sformatf("seg%0d_pulses", k), pulses, segs[k].exp_pulses);
    end

    // Random segments, occasional reset
    for (int r = 0; r < 60; r++) begin
      enable = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      speed_ctrl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin rst_n = 0; clk1(); rst_n = 1; end
      for (int c = 0, n = $urandom_range(1, 60); c < n; c++) clk1();
    end

    // Speed change mid-interval only takes effect at the next step boundary
    enable = 1; mode = 2'd1; speed_ctrl = 2'd0;
    do_reset();
    hi0 = 0;
    for (int c = 0; c < 15; c++) begin clk1(); if (led_out[0]) hi0++; end
    speed_ctrl = 2'd3;
    for (int c = 15; c < 47; c++) begin clk1(); if (led_out[0]) hi0++; end
    check("speed_switch_ch0_high", hi0, 3);

    // Reset during the ch0 down-ramp aborts the breath
    speed_ctrl = 2'd3;
    do_reset();
    for (int c = 0; c < 300; c++) clk1();
    rst_n = 0; clk1(); rst_n = 1;
    check("midreset_led", led_out, 0);
    check("midreset_wd", wave_done, 0);
    edge_no = 0; pulses = 0; first_pulse = -1;
    hi0 = 0; hi1 = 0;
    for (int c = 0; c < MAXV; c++) begin
      clk1();
      if (led_out[0]) hi0++;
      if (led_out[1]) hi1++;
    end
    check("midreset_ch0_high", hi0, 0);
    check("midreset_ch1_high", hi1, 8);
    for (int c = MAXV; c < 450; c++) clk1();
    check("midreset_pulses", pulses, 1);
    check("midreset_first_pulse", first_pulse, 450);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
